sc_random_arbiter: RTL and testbench

Round-robin arbiter that shares the free-running 8-bit LFSR random source between up to NREQ requesters, such as obstacle spawners and score effects. For each granted request it captures one LFSR word, masks it into a range and rejects out-of-range values. Consecutive captures are spaced at least GAP clocks apart, so successive values are not shifted copies of each other. It sits between the LFSR output bus and the game-logic blocks.

---
 rtl/sc_random_arbiter_if.sv | 32 +++
 rtl/sc_random_arbiter.sv | 126 ++++++++++++
 tb/tb_sc_random_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sc_random_arbiter_if.sv
// Bus between the shared LFSR arbiter and its requesters: random word in,
// per-requester request levels in, one-hot ack pulse and delivered value out.
interface sc_random_arbiter_if #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDXW      = 2
) ();
  logic [DATAWIDTH-1:0] SC_RANDOM_data_InBUS;
  logic [NREQ-1:0]      SC_RANDOM_req_InBUS;
  logic [NREQ-1:0]      SC_RANDOM_ack_OutBUS;
  logic [DATAWIDTH-1:0] SC_RANDOM_value_OutBUS;
  logic [IDXW-1:0]      SC_RANDOM_grant_OutBUS;
  logic                 SC_RANDOM_busy_OutHigh;

  modport master (
    input  SC_RANDOM_data_InBUS,
    input  SC_RANDOM_req_InBUS,
    output SC_RANDOM_ack_OutBUS,
    output SC_RANDOM_value_OutBUS,
    output SC_RANDOM_grant_OutBUS,
    output SC_RANDOM_busy_OutHigh
  );

  modport slave (
    output SC_RANDOM_data_InBUS,
    output SC_RANDOM_req_InBUS,
    input  SC_RANDOM_ack_OutBUS,
    input  SC_RANDOM_value_OutBUS,
    input  SC_RANDOM_grant_OutBUS,
    input  SC_RANDOM_busy_OutHigh
  );
endinterface

// File: rtl/sc_random_arbiter.sv
// Round-robin arbiter sharing one free-running LFSR word between requesters;
// each grant captures a word, masks it, rejects out-of-range values and retries.
module sc_random_arbiter #(
  parameter int                   DATAWIDTH = 8,
  parameter int                   NREQ      = 4,
  parameter int                   IDXW      = 2,
  parameter logic [DATAWIDTH-1:0] MASK      = 8'h0F,
  parameter logic [DATAWIDTH-1:0] LIMIT     = 8'd9,
  parameter int                   GAP       = 8,
  parameter int                   MAX_TRIES = 4
) (
  input logic                SC_RANDOM_CLOCK_50,
  input logic                SC_RANDOM_RESET_InHigh,
  sc_random_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANT, CHECK, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [IDXW-1:0]      r_rrPtr;
  logic [IDXW-1:0]      r_grant;
  logic [3:0]           r_tries;
  logic [DATAWIDTH-1:0] r_sample;
  logic [DATAWIDTH-1:0] r_value;
  logic [7:0]           r_gapCnt;

  logic [IDXW-1:0]      w_pick;
  logic [IDXW-1:0]      w_nextPtr;
  logic                 w_anyReq;
  logic                 w_keep;
  logic                 w_gapOk;
  logic                 w_capture;
  logic                 w_lastTry;
  logic [DATAWIDTH-1:0] w_masked;
  logic                 w_inRange;
  logic [NREQ-1:0]      w_ack;
  logic                 w_busy;

  function automatic logic [IDXW-1:0] wrapIdx(input logic [IDXW-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDXW'(sum);
  endfunction

  // Lowest offset from the round-robin pointer wins, so scan downward and let the last hit stick.
  always_comb begin
    w_pick = r_rrPtr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.SC_RANDOM_req_InBUS[wrapIdx(r_rrPtr, k)]) w_pick = wrapIdx(r_rrPtr, k);
    end
  end

  assign w_anyReq  = |bus.SC_RANDOM_req_InBUS;
  assign w_keep    = bus.SC_RANDOM_req_InBUS[r_grant];
  assign w_gapOk   = (r_gapCnt >= 8'(GAP));
  assign w_capture = (r_state == GRANT) && w_keep && w_gapOk;
  assign w_lastTry = (r_tries == 4'(MAX_TRIES));
  assign w_masked  = r_sample & MASK;
  assign w_inRange = (w_masked <= LIMIT);
  assign w_nextPtr = (r_grant == IDXW'(NREQ - 1)) ? '0 : r_grant + IDXW'(1);

  always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
    if (SC_RANDOM_RESET_InHigh) r_state <= IDLE;
    else                        r_state <= w_nextState;
  end

  // A dropped request in GRANT or CHECK abandons the transaction without an ack.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = GRANT;
      GRANT:   if (!w_keep) w_nextState = IDLE;
               else if (w_gapOk) w_nextState = CHECK;
      CHECK:   if (!w_keep) w_nextState = IDLE;
               else if (w_inRange || w_lastTry) w_nextState = DONE;
               else w_nextState = GRANT;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_ack  = '0;
    w_busy = (r_state != IDLE);
    if (r_state == DONE) w_ack[r_grant] = 1'b1;
  end

  // The gap counter counts clocks since the capture edge, so the capture clock itself is clock 1.
  always_ff @(posedge SC_RANDOM_CLOCK_50 or posedge SC_RANDOM_RESET_InHigh) begin
    if (SC_RANDOM_RESET_InHigh) begin
      r_rrPtr  <= '0;
      r_grant  <= '0;
      r_tries  <= '0;
      r_sample <= '0;
      r_value  <= '0;
      r_gapCnt <= 8'(GAP);
    end else begin
      if (w_capture)                 r_gapCnt <= 8'd1;
      else if (r_gapCnt < 8'(GAP))   r_gapCnt <= r_gapCnt + 8'd1;
      case (r_state)
        IDLE: if (w_anyReq) begin
          r_grant <= w_pick;
          r_tries <= '0;
        end
        GRANT: if (w_capture) begin
          r_sample <= bus.SC_RANDOM_data_InBUS;
          r_tries  <= r_tries + 4'd1;
        end
        CHECK: if (w_keep) begin
          if (w_inRange)      r_value <= w_masked;
          else if (w_lastTry) r_value <= '0;
        end
        DONE: r_rrPtr <= w_nextPtr;
        default: ;
      endcase
    end
  end

  assign bus.SC_RANDOM_ack_OutBUS   = w_ack;
  assign bus.SC_RANDOM_value_OutBUS = r_value;
  assign bus.SC_RANDOM_grant_OutBUS = r_grant;
  assign bus.SC_RANDOM_busy_OutHigh = w_busy;

endmodule

// File: tb/tb_sc_random_arbiter.sv
// Self-checking bench for sc_random_arbiter: table of single-requester vectors
// plus hand sequences for round-robin, retry, abort and mid-transaction reset.
module tb_sc_random_arbiter;

  logic       clock;
  logic       reset;
  logic [7:0] data;
  logic [3:0] req;
  int         cycle;
  int         compareCount;
  int         failCount;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] value;
    logic [1:0] grant;
    int         expCycle;
  } exp_t;

  typedef struct {
    int         reqIdx;
    logic [7:0] data;
    logic [7:0] expValue;
    int         expLatency;
  } vec_t;

  exp_t expQ[$];
  exp_t monExp;
  vec_t vecs[8];

  sc_random_arbiter_if #(.DATAWIDTH(8), .NREQ(4), .IDXW(2)) bus ();

  sc_random_arbiter dut (
    .SC_RANDOM_CLOCK_50    (clock),
    .SC_RANDOM_RESET_InHigh(reset),
    .bus                   (bus)
  );

  assign bus.SC_RANDOM_data_InBUS = data;
  assign bus.SC_RANDOM_req_InBUS  = req;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle = 0;
  always @(posedge clock) cycle = cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int required);
    compareCount++;
    if (actual != required) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cycle);
    end
  endtask

  task automatic pushExp(input logic [3:0] ack, input logic [7:0] value, input logic [1:0] grant,
                         input int expCycle);
    exp_t e;
    e.ack      = ack;
    e.value    = value;
    e.grant    = grant;
    e.expCycle = expCycle;
    expQ.push_back(e);
  endtask

  task automatic waitDrained(input int budget);
    for (int i = 0; i < budget && expQ.size() != 0; i++) begin
      @(posedge clock); #2;
    end
    if (expQ.size() != 0) begin
      checkOutput("ackTimeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [3:0] oneHot;
    @(posedge clock); #2;
    oneHot = 4'b0001 << v.reqIdx;
    data   = v.data;
    req    = oneHot;
    pushExp(oneHot, v.expValue, 2'(v.reqIdx), cycle + v.expLatency);
    waitDrained(60);
    req = 4'b0000;
    checkOutput("busyAfterAck", int'(bus.SC_RANDOM_busy_OutHigh), 0);
    checkOutput("ackPulseWidth", int'(bus.SC_RANDOM_ack_OutBUS), 0);
    repeat (12) @(posedge clock);
  endtask

  // Every ack must match the oldest outstanding expectation, including the cycle it appears in.
  always @(negedge clock) begin
    if (!reset && bus.SC_RANDOM_ack_OutBUS != 4'b0000) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedAck", int'(bus.SC_RANDOM_ack_OutBUS), 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("ack", int'(bus.SC_RANDOM_ack_OutBUS), int'(monExp.ack));
        checkOutput("value", int'(bus.SC_RANDOM_value_OutBUS), int'(monExp.value));
        checkOutput("grant", int'(bus.SC_RANDOM_grant_OutBUS), int'(monExp.grant));
        checkOutput("ackCycle", cycle, monExp.expCycle);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    compareCount = 0;
    failCount    = 0;
    reset        = 1'b1;
    data         = 8'h00;
    req          = 4'b0000;

    vecs[0] = '{0, 8'h25, 8'h05, 3};
    vecs[1] = '{1, 8'h09, 8'h09, 3};
    vecs[2] = '{2, 8'h0A, 8'h00, 27};
    vecs[3] = '{0, 8'h1A, 8'h00, 27};
    vecs[4] = '{1, 8'h37, 8'h07, 3};
    vecs[5] = '{2, 8'hFF, 8'h00, 27};
    vecs[6] = '{0, 8'hF0, 8'h00, 3};
    vecs[7] = '{3, 8'h86, 8'h06, 3};

    repeat (3) @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checkOutput("resetAck", int'(bus.SC_RANDOM_ack_OutBUS), 0);
    checkOutput("resetValue", int'(bus.SC_RANDOM_value_OutBUS), 0);
    checkOutput("resetGrant", int'(bus.SC_RANDOM_grant_OutBUS), 0);
    checkOutput("resetBusy", int'(bus.SC_RANDOM_busy_OutHigh), 0);
    repeat (2) @(posedge clock);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] round-robin with all requesters held");
    @(posedge clock); #2;
    c0   = cycle;
    data = 8'h03;
    req  = 4'b1111;
    pushExp(4'b0001, 8'h03, 2'd0, c0 + 3);
    pushExp(4'b0010, 8'h03, 2'd1, c0 + 11);
    pushExp(4'b0100, 8'h03, 2'd2, c0 + 19);
    pushExp(4'b1000, 8'h03, 2'd3, c0 + 27);
    pushExp(4'b0001, 8'h03, 2'd0, c0 + 35);
    waitDrained(80);
    req = 4'b0000;
    repeat (12) @(posedge clock);

    $display("[TB] reject then retry");
    @(posedge clock); #2;
    c0   = cycle;
    data = 8'h0C;
    req  = 4'b0001;
    pushExp(4'b0001, 8'h07, 2'd0, c0 + 11);
    repeat (2) @(posedge clock); #2;
    data = 8'h07;
    waitDrained(60);
    req = 4'b0000;
    repeat (12) @(posedge clock);

    $display("[TB] abort after a reject");
    @(posedge clock); #2;
    data = 8'h0C;
    req  = 4'b0010;
    repeat (3) @(posedge clock); #2;
    req = 4'b0000;
    repeat (12) @(posedge clock); #2;
    checkOutput("abortValueHeld", int'(bus.SC_RANDOM_value_OutBUS), 7);
    checkOutput("abortBusy", int'(bus.SC_RANDOM_busy_OutHigh), 0);
    c0   = cycle;
    data = 8'h03;
    req  = 4'b0110;
    pushExp(4'b0010, 8'h03, 2'd1, c0 + 3);
    pushExp(4'b0100, 8'h03, 2'd2, c0 + 11);
    waitDrained(60);
    req = 4'b0000;
    repeat (12) @(posedge clock);

    $display("[TB] reset while in CHECK");
    @(posedge clock); #2;
    data = 8'h05;
    req  = 4'b1000;
    repeat (2) @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checkOutput("midResetAck", int'(bus.SC_RANDOM_ack_OutBUS), 0);
    checkOutput("midResetValue", int'(bus.SC_RANDOM_value_OutBUS), 0);
    checkOutput("midResetBusy", int'(bus.SC_RANDOM_busy_OutHigh), 0);
    checkOutput("midResetGrant", int'(bus.SC_RANDOM_grant_OutBUS), 0);
    req = 4'b0000;
    @(posedge clock); #2;
    reset = 1'b0;
    applyStimulus('{0, 8'h25, 8'h05, 3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
